// File: rtl/exc_sequencer.sv
// exc_sequencer: exception and interrupt sequencer for the multicycle MIPS core.
// It detects invalid opcodes, signed overflow and external interrupts, then
// aborts the current instruction, saves EPC and a cause code, vectors the PC
// to the handler and later restores the PC from EPC on eret.
// A second synchronous event inside the handler is a double fault and halts the core.
// Build option: define EXC_IRQ_EN to enable the external interrupt path.
// Without it the irq input is ignored and cause 11 is never produced.
module exc_sequencer #(
   parameter logic [31:0] VEC_OPCODE = 32'h0000_0100,
   parameter logic [31:0] VEC_OVF    = 32'h0000_0104,
   parameter logic [31:0] VEC_IRQ    = 32'h0000_0108
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_boundary,
   input  logic        invalid_op,
   input  logic        ovf_check,
   input  logic        overflow,
   input  logic        irq,
   input  logic        eret,
   input  logic [31:0] pc,
   output logic        exc_take,
   output logic        pc_override_en,
   output logic [31:0] pc_override,
   output logic [31:0] epc,
   output logic [1:0]  cause,
   output logic        in_handler,
   output logic        irq_ack,
   output logic        exc_halt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAVE    = 3'd1,
      VECTOR  = 3'd2,
      HANDLER = 3'd3,
      RETURN  = 3'd4,
      HALT    = 3'd5
   } state_t;

   localparam logic [1:0] CAUSE_OPCODE = 2'b01;
   localparam logic [1:0] CAUSE_OVF    = 2'b10;
   localparam logic [1:0] CAUSE_IRQ    = 2'b11;

   state_t      state;
   state_t      state_nxt;
   logic        sync_ev;
   logic        ovf_ev;
   logic        irq_pending;
   logic        irq_take;
   logic [31:0] lat_epc;
   logic [31:0] lat_epc_nxt;
   logic [1:0]  lat_cause;
   logic [1:0]  lat_cause_nxt;

   assign ovf_ev  = ovf_check & overflow;
   assign sync_ev = invalid_op | ovf_ev;

`ifdef EXC_IRQ_EN
   // Remember an interrupt request until it is acknowledged; a new request wins over the ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_pending <= 1'b0;
      end else if (irq) begin
         irq_pending <= 1'b1;
      end else if (irq_ack) begin
         irq_pending <= 1'b0;
      end
   end

   assign irq_ack = (state == SAVE) && (lat_cause == CAUSE_IRQ);
`else
   logic irq_unused;

   assign irq_unused  = irq;
   assign irq_pending = 1'b0;
   assign irq_ack     = 1'b0;
`endif

   // Interrupts are only accepted between instructions, so nothing is in flight.
   assign irq_take = irq_pending & fetch_boundary;

   // Sequencer state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and the EPC/cause candidates captured when an event is accepted.
   always_comb begin
      state_nxt     = state;
      lat_epc_nxt   = lat_epc;
      lat_cause_nxt = lat_cause;
      case (state)
         IDLE: begin
            // PC was already incremented at fetch, so a faulting instruction sits at pc-4.
            if (invalid_op) begin
               state_nxt     = SAVE;
               lat_cause_nxt = CAUSE_OPCODE;
               lat_epc_nxt   = pc - 32'd4;
            end else if (ovf_ev) begin
               state_nxt     = SAVE;
               lat_cause_nxt = CAUSE_OVF;
               lat_epc_nxt   = pc - 32'd4;
            end else if (irq_take) begin
               state_nxt     = SAVE;
               lat_cause_nxt = CAUSE_IRQ;
               lat_epc_nxt   = pc;
            end
         end
         SAVE:    state_nxt = VECTOR;
         VECTOR:  state_nxt = HANDLER;
         HANDLER: begin
            if (eret) begin
               state_nxt = RETURN;
            end else if (sync_ev) begin
               state_nxt = HALT;
            end
         end
         RETURN:  state_nxt = IDLE;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   // Candidate EPC/cause held between acceptance and the SAVE cycle.
   always_ff @(posedge clock) begin
      lat_epc   <= lat_epc_nxt;
      lat_cause <= lat_cause_nxt;
   end

   // Architectural EPC and cause change only in SAVE, so a double fault keeps the first values.
   always_ff @(posedge clock) begin
      if (reset) begin
         epc   <= 32'd0;
         cause <= 2'b00;
      end else if (state == SAVE) begin
         epc   <= lat_epc;
         cause <= lat_cause;
      end
   end

   assign exc_take       = (state == SAVE);
   assign pc_override_en = (state == VECTOR) || (state == RETURN);
   assign in_handler     = (state == HANDLER);
   assign exc_halt       = (state == HALT);

   // PC override source: handler vector by cause, or EPC on return.
   // Cause 11 cannot be reached when the interrupt path is disabled.
   always_comb begin
      pc_override = 32'd0;
      if (state == VECTOR) begin
         case (cause)
            CAUSE_OPCODE: pc_override = VEC_OPCODE;
            CAUSE_OVF:    pc_override = VEC_OVF;
            CAUSE_IRQ:    pc_override = VEC_IRQ;
            default:      pc_override = 32'd0;
         endcase
      end else if (state == RETURN) begin
         pc_override = epc;
      end
   end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception and interrupt sequencer for the multicycle MIPS datapath. Watches the ALU overflow flag, the control unit's invalid-opcode decode and an external interrupt line. On an event it:
- tells the control unit to abandon the current instruction,
- captures EPC and a cause code,
- forces the PC mux to the handler vector,
- later restores PC from EPC on a return-from-exception.

It sits beside the control unit and drives the PC-load override path into the PC register.

## Interface
- VEC_OPCODE, 32'h0000_0100, handler address for invalid opcode
- VEC_OVF, 32'h0000_0104, handler address for arithmetic overflow
- VEC_IRQ, 32'h0000_0108, handler address for external interrupt

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- fetch_boundary  in  1  control unit is in its fetch state (instruction boundary)
- invalid_op  in  1  control unit decoded an unknown opcode this cycle
- ovf_check  in  1  control unit is in a signed add/sub execute state
- overflow  in  1  ALU overflow flag; meaningful only when ovf_check=1
- irq  in  1  external interrupt request, level
- eret  in  1  control unit decoded return-from-exception this cycle
- pc  in  32  current PC register output
- exc_take  out  1  one-cycle pulse: abort instruction, return to fetch, suppress PCWrite/RegWrite/wr
- pc_override_en  out  1  PC register loads pc_override this cycle
- pc_override  out  32  value for the PC register
- epc  out  32  saved exception PC
- cause  out  2  00 none, 01 invalid opcode, 10 overflow, 11 irq
- in_handler  out  1  handler running; irq masked
- irq_ack  out  1  one-cycle pulse when an irq is accepted
- exc_halt  out  1  double fault; core must stop

## Operation
- States: IDLE, SAVE, VECTOR, HANDLER, RETURN, HALT.

**Event detection**
- sync_ev = invalid_op | (ovf_check & overflow).
- Priority: invalid_op > overflow > irq.
- irq_pending is set on any cycle with irq=1. It is cleared by irq_ack or reset.

**IDLE**
- sync_ev=1 → SAVE with cause 01/10. Latched epc = pc − 4, because PC was already incremented at fetch.
- Else, if irq_pending=1 and fetch_boundary=1 → SAVE with cause 11. Latched epc = pc, because no instruction is in flight.
- Otherwise stay in IDLE.

**SAVE**
- exc_take=1.
- epc and cause registers load the latched values.
- irq_ack=1 when cause=11.
- → VECTOR.

**VECTOR**
- pc_override_en=1.
- pc_override = VEC_* selected by cause.
- → HANDLER.

**HANDLER**
- in_handler=1; irq stays pending but is not taken.
- eret=1 → RETURN.
- sync_ev=1 → HALT (double fault). epc and cause are not overwritten.

**RETURN**
- pc_override_en=1, pc_override=epc → IDLE.

**HALT**
- exc_halt=1. Held until reset.

**Other rules**
- eret outside HANDLER is ignored.
- epc and cause hold their values until the next SAVE.
- pc − 4 is modulo 2^32: pc=0 gives epc=32'hFFFF_FFFC.

## Timing
- Reset: state IDLE; every output 0; epc=0, cause=00; irq_pending=0. Reset wins over every event in the same cycle, including mid-SAVE, VECTOR or HANDLER.
- sync_ev in IDLE cycle N:
  - exc_take in N+1;
  - pc_override_en in N+2;
  - in_handler from N+3.
  - The handler's first fetch uses the PC loaded at the end of N+2.
- irq set in cycle N: earliest accept is the first cycle ≥ N+1 with fetch_boundary=1.
- eret in HANDLER cycle M: pc_override_en in M+1; IDLE from M+2. A pending irq may be accepted from M+2.
- sync_ev and irq_pending in the same IDLE cycle: the sync event is taken and the irq stays pending.
- Outputs are registered from state, except pc_override, which is a mux of registered values.

## Configuration
- EXC_IRQ_EN defined:
  - irq input, irq_pending, irq_ack and cause 11 are functional;
  - pc_override may select VEC_IRQ.
- EXC_IRQ_EN undefined:
  - irq port is still present but ignored;
  - irq_pending is constant 0 and irq_ack is tied to 0;
  - cause 11 is never produced.

## Test plan
- Reset, then pc=32'h0000_0040, invalid_op=1 for one cycle → exc_take next cycle; then pc_override_en=1 with pc_override=32'h0000_0100; epc=32'h0000_003C; cause=01; in_handler=1.
- ovf_check=1, overflow=1, pc=32'h0000_0020 → cause=10, epc=32'h0000_001C, vector 32'h0000_0104. Also overflow=1 with ovf_check=0 → no reaction.
- irq pulsed 1 cycle while fetch_boundary=0, then fetch_boundary=1 with pc=32'h0000_0080 → irq_ack 1 cycle, cause=11, epc=32'h0000_0080, vector 32'h0000_0108. Without EXC_IRQ_EN → no reaction.
- In HANDLER, eret=1 → next cycle pc_override_en=1 with pc_override=epc; a pending irq is then accepted at the next fetch_boundary, not before.
- In HANDLER, invalid_op=1 → exc_halt=1 held for 10+ cycles and epc unchanged; reset → exc_halt=0, epc=0, cause=00.
- invalid_op, overflow with ovf_check, and irq_pending all in one IDLE cycle → cause=01 and irq still pending.
